// File: rtl/sync_fifo_n.sv
// Single-clock FIFO of DEPTH x WIDTH with occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_n #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] AfCount = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AeCount = PW'(AE_LEVEL);
  localparam logic [PW-1:0] FullCount = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok, pop_ok;

  // Pointers carry a wrap bit, so their difference is the exact occupancy 0..DEPTH.
  assign count        = wptr_q - rptr_q;
  assign full         = (count == FullCount);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AfCount);
  assign almost_empty = (count <= AeCount);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && full) begin
      overflow_d = 1'b1;
    end
    if (pop && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wptr_q[AW-1:0]] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = empty ? '0 : mem[rptr_q[AW-1:0]];
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (pop_ok) begin
      rdata_q <= mem[rptr_q[AW-1:0]];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: doc/sync_fifo_n.md
# sync_fifo_n

Single-clock, parametrised-width, parametrised-depth FIFO that extends the two-entry push/pop FIFO to arbitrary power-of-two depth. Adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain, using the same push/full and pop/empty handshake as the existing FIFOs.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

- clk  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- push  input  1  write request
- wdata  input  WIDTH  write data, sampled with an accepted push
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AF_LEVEL
- pop  input  1  read request
- rdata  output  WIDTH  read data (timing per Configuration)
- empty  output  1  count == 0
- almost_empty  output  1  count <= AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push seen while full
- underflow  output  1  sticky: pop seen while empty

## Operation
- Storage: DEPTH x WIDTH array. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. The low bits index the array.
- full, almost_full, empty, almost_empty are pure functions of the registered count and have no extra pipeline stage.
- Accept rules use flags as they stand at the sampling edge:
  - push_ok = push & !full
  - pop_ok = pop & !empty
- On push_ok: mem[wptr] <= wdata and wptr increments. On pop_ok: rptr increments.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, count unchanged.
  - When full: the push is rejected even though a pop occurs in the same cycle; the pop is accepted; overflow sets.
  - When empty: the push is accepted, the pop is rejected, underflow sets.
- Rejected operations never modify the pointers, storage or count.
- count arithmetic:
  - +1 on push_ok only
  - -1 on pop_ok only
  - unchanged when both or neither
  - never wraps outside 0..DEPTH
- Pointer wrap: the low bits roll from DEPTH-1 to 0 and the MSB toggles. Wrap is transparent to data ordering.
- overflow and underflow are sticky. Only reset clears them.
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0 (given AF_LEVEL>=1), overflow=0, underflow=0, rdata=0, pointers=0. Storage contents are not reset.
- A reset asserted mid-operation discards all contents at that edge. The next cycle presents the reset values.

## Timing
- Push at edge N: count and flags reflect the new entry from edge N (visible in cycle N+1).
- Write-to-empty-deassert latency is one edge.
- Pop at edge N: count and flags update from edge N.
- overflow and underflow assert from the edge that saw the illegal request.
- No combinational path from push/pop to full/empty/count.

## Configuration
- SYNC_FIFO_FWFT_EN defined (first-word-fall-through):
  - rdata = mem[rptr] combinationally whenever !empty; rdata = 0 when empty.
  - The head word is visible in the cycle after the push that made the FIFO non-empty.
  - pop consumes the displayed word.
- SYNC_FIFO_FWFT_EN undefined (registered read):
  - rdata is a register, loaded with mem[rptr] at an edge with pop_ok.
  - Data is valid from that edge, i.e. one cycle after pop is sampled.
  - rdata holds its value otherwise. Reset value is 0.

## Test plan
- Reset, then idle 3 cycles -> empty=1, almost_empty=1, full=0, count=0, overflow=0, underflow=0, rdata=0.
- Push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) -> count 1,2,3,4; almost_full at count 3; full at 4. Pop 4 -> data 0x11..0x44 in order (same cycle under FWFT, one cycle after pop otherwise). Ends empty=1.
- Fill to 4, then push 0x55 with pop in the same cycle -> 0x11 popped, 0x55 dropped, count=3, overflow=1 and stays 1 until reset.
- From empty, push 0xA5 with pop in the same cycle -> underflow=1, count=1. The next pop returns 0xA5.
- Run 10 push/pop pairs through a half-full FIFO, crossing pointer wrap twice -> output order matches input order, count remains 2.
- Fill to 3, assert reset for one cycle -> next cycle count=0, empty=1, sticky flags 0. A subsequent push/pop of 0x7E returns 0x7E.
